mul_seq: RTL and testbench

- Multi-cycle shift-add multiplier in the 8-bit datapath.
- Takes two `N-wide operands through a valid/ready handshake and iterates one bit per clock.
- Returns a 2*`N-bit product through a second valid/ready handshake.
- prod_lo feeds the writeback-select 3-way mux (in2 leg). prod_hi goes to the high-result register.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/mul_seq_dp.sv | 53 +++++
 rtl/mul_seq.sv | 101 ++++++++++
 tb/tb_mul_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: operand width,
// controller state encoding and the magnitude helper.
`ifndef N
`define N 8
`endif

package mul_pkg;

  localparam int WIDTH = `N;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // The most negative value maps to itself, which reads correctly as its unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Datapath for mul_seq: magnitude registers, shift-add accumulator and the final
// sign fix-up of the product.
module mul_seq_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   mag_a_in,
  input  logic [WIDTH-1:0]   mag_b_in,
  input  logic               neg_in,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic               neg;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_nxt;
  logic [WIDTH-1:0]   mplier_nxt;
  logic [2*WIDTH-1:0] p;

  assign addend     = mplier[0] ? mag_a : '0;
  assign sum        = acc + {1'b0, addend};
  assign acc_nxt    = sum >> 1;
  assign mplier_nxt = {sum[0], mplier[WIDTH-1:1]};

  // acc_nxt's top bit is always zero after the shift, so truncation loses nothing.
  assign p      = (2*WIDTH)'({acc_nxt, mplier_nxt});
  assign result = !finish ? '0 : (neg ? -p : p);

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mag_a  <= mag_a_in;
      mplier <= mag_b_in;
      acc    <= '0;
      neg    <= neg_in;
    end else if (step) begin
      acc    <= acc_nxt;
      mplier <= mplier_nxt;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock, operands and
// product each carried over a valid/ready handshake.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH,
  parameter int CNT_W = mul_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and data stable until that edge.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               load, step, finish;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg;
  logic [2*WIDTH-1:0] result;

  assign start_ready = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

  assign mag_a = abs_val(a, signed_mode);
  assign mag_b = abs_val(b, signed_mode);
  assign neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      res_valid <= 1'b0;
      prod_lo   <= '0;
      prod_hi   <= '0;
    end else begin
      state_q <= state_d;
      if (load) cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
      // Product registers keep their value after consumption until the next result.
      if (finish) begin
        prod_lo   <= result[WIDTH-1:0];
        prod_hi   <= result[2*WIDTH-1:WIDTH];
        res_valid <= 1'b1;
      end else if (state_q == DONE && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .finish   (finish),
    .mag_a_in (mag_a),
    .mag_b_in (mag_b),
    .neg_in   (neg),
    .result   (result)
  );

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: transaction-level model plus scoreboard,
// directed corner cases and a randomized phase.
module tb_mul_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         start_ready, res_valid, busy;
  logic [W-1:0] prod_lo, prod_hi;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mul_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .prod_lo     (prod_lo),
    .prod_hi     (prod_hi),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helpers ----------------
  task automatic fail_msg(input string name, input string act, input string exp);
    errors++;
    $display("FAIL %s: got %s, expected %s (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) fail_msg(name, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) fail_msg(name, $sformatf("%h", act), $sformatf("%h", exp));
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) fail_msg(name, $sformatf("%0d", act), $sformatf("%0d", exp));
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    logic signed [2*W-1:0] sx, sy;
    logic [2*W-1:0] ux, uy;
    if (sm) begin
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      return sx * sy;
    end
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    return ux * uy;
  endfunction

  // Phase: 0 waiting for operands, 1 computing, 2 holding a result.
  int           m_phase = 0;
  int           m_left = 0;
  logic         m_valid = 1'b0;
  logic [15:0]  m_prod = '0;
  logic [15:0]  m_pend = '0;
  logic [15:0]  exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_valid <= 1'b0;
      m_prod  <= '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (start_valid) begin
          m_pend  <= ref_prod(a, b, signed_mode);
          exp_q.push_back(ref_prod(a, b, signed_mode));
          m_left  <= W;
          m_phase <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_valid <= 1'b1;
            m_prod  <= m_pend;
          end
        end
        default: if (res_ready) begin
          m_valid <= 1'b0;
          m_phase <= 0;
        end
      endcase
    end
  end

  // ---------------- compare process / scoreboard ----------------
  initial begin
    logic [15:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk1("start_ready", start_ready, (m_phase == 0) && !rst);
      chk1("busy", busy, m_phase != 0);
      chk1("res_valid", res_valid, m_valid);
      chk16("prod", {prod_hi, prod_lo}, m_prod);
      if (res_valid && res_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          fail_msg("sb_unexpected_result", $sformatf("%h", {prod_hi, prod_lo}), "no result pending");
        end else begin
          e = exp_q.pop_front();
          chk16("sb_prod", {prod_hi, prod_lo}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                       output int acc_cyc);
    start_valid = 1'b1;
    a = x;
    b = y;
    signed_mode = sm;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (start_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start_valid = 1'b0;
        return;
      end
      tick();
    end
    start_valid = 1'b0;
    checks++;
    fail_msg("accept_timeout", "start_ready low", "accept within 40 cycles");
  endtask

  task automatic wait_result(input int acc_cyc, input logic [15:0] exp_p, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) begin
        chki({name, "_latency"}, cyc - acc_cyc, W);
        chk16(name, {prod_hi, prod_lo}, exp_p);
        return;
      end
    end
    checks++;
    fail_msg({name, "_timeout"}, "res_valid low", "res_valid within 40 cycles");
  endtask

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sm;
    logic [15:0]  p;
  } vec_t;

  vec_t vecs[5];
  int   c0;
  int   acc_list[$];

  initial begin
    vecs[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[2] = '{8'h7F, 8'hFE, 1'b1, 16'hFF02};
    vecs[3] = '{8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[4] = '{8'h00, 8'hAB, 1'b0, 16'h0000};

    // model pinned against hand-computed products
    chk16("model_ff_ff", ref_prod(8'hFF, 8'hFF, 1'b0), 16'hFE01);
    chk16("model_m128_sq", ref_prod(8'h80, 8'h80, 1'b1), 16'h4000);

    repeat (3) tick();
    @(negedge clk);
    chk1("rst_start_ready", start_ready, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_prod", {prod_hi, prod_lo}, 16'h0000);
    chk16("rst_state", {14'd0, state_dbg}, 16'h0000);
    rst = 1'b0;
    tick();
    chk1("idle_start_ready", start_ready, 1'b1);

    // 0xFF * 0xFF unsigned, consumer always ready
    res_ready = 1'b1;
    issue(8'hFF, 8'hFF, 1'b0, c0);
    wait_result(c0, 16'hFE01, "uu_ff_ff");
    chk1("ff_start_ready_in_done", start_ready, 1'b0);
    @(negedge clk);
    chk1("ff_valid_one_cycle", res_valid, 1'b0);
    chk1("ff_start_ready_after", start_ready, 1'b1);
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].x, vecs[i].y, vecs[i].sm, c0);
      wait_result(c0, vecs[i].p, $sformatf("vec%0d", i));
      tick();
    end

    // backpressure with ignored requests while the result is held
    res_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, c0);
    wait_result(c0, 16'h03A8, "bp");
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
      chk1("bp_start_ready", start_ready, 1'b0);
      chk1("bp_res_valid", res_valid, 1'b1);
      chk16("bp_prod", {prod_hi, prod_lo}, 16'h03A8);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk1("bp_consumed_busy", busy, 1'b0);
    chk16("bp_prod_kept", {prod_hi, prod_lo}, 16'h03A8);
    tick();

    // reset in the middle of CALC
    issue(8'h09, 8'h07, 1'b0, c0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk16("mid_rst_state", {14'd0, state_dbg}, 16'h0000);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_valid", res_valid, 1'b0);
    chk16("mid_rst_prod", {prod_hi, prod_lo}, 16'h0000);
    rst = 1'b0;
    repeat (15) tick();
    issue(8'h03, 8'h05, 1'b0, c0);
    wait_result(c0, 16'h000F, "after_rst");
    tick();

    // operands presented continuously: back-to-back issue
    a = 8'h0A;
    b = 8'h0A;
    signed_mode = 1'b0;
    start_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start_ready && start_valid) acc_list.push_back(cyc + 1);
      if (res_valid) chk16("b2b_prod", {prod_hi, prod_lo}, 16'h0064);
    end
    start_valid = 1'b0;
    if (acc_list.size() < 2) begin
      checks++;
      fail_msg("b2b_accepts", $sformatf("%0d", acc_list.size()), "at least 2");
    end else begin
      chki("b2b_interval", acc_list[1] - acc_list[0], W + 2);
    end
    repeat (20) tick();

    // randomized traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
